// File: rtl/block_move_ctrl.sv
// Block-move motion controller: debounces four active-low keys and applies one bounded step
// per frame to the block origin. Define BLOCK_MOVE_CTRL_WRAP_EN to wrap at the edges instead of clamping.
module block_move_ctrl #(
  parameter int unsigned H_DISP     = 640,
  parameter int unsigned V_DISP     = 480,
  parameter int unsigned BLOCK_SIZE = 40,
  parameter int unsigned STEP       = 2,
  parameter int unsigned DEB_CYCLES = 250000,
  parameter int unsigned X_INIT     = 300,
  parameter int unsigned Y_INIT     = 220
) (
  input  logic       vga_clk,
  input  logic       sys_rst,
  input  logic [3:0] key,
  input  logic       frame_start,
  output logic [9:0] block_x,
  output logic [9:0] block_y,
  output logic [3:0] key_db,
  output logic       moving
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);
  localparam logic signed [10:0] XMax  = 11'(H_DISP - BLOCK_SIZE);
  localparam logic signed [10:0] YMax  = 11'(V_DISP - BLOCK_SIZE);
  localparam logic signed [10:0] StepS = 11'(STEP);

  typedef enum logic [1:0] {StIdle, StCalc, StCommit} state_e;

  state_e            state_q;
  logic [3:0]        sync1_q, sync2_q;
  logic [CntW-1:0]   cnt_q [4];
  logic [3:0]        dir_q;
  logic signed [10:0] nx_q, ny_q;
  logic [9:0]        bx_d, by_d;

  // Step along one axis; opposing keys cancel.
  function automatic logic signed [10:0] axis_step(input logic [9:0] c, input logic minus,
                                                   input logic plus);
    logic signed [10:0] cs;
    cs = $signed({1'b0, c});
    if (minus && !plus)      return cs - StepS;
    else if (plus && !minus) return cs + StepS;
    else                     return cs;
  endfunction

  function automatic logic [9:0] bound(input logic signed [10:0] v,
                                       input logic signed [10:0] vmax);
`ifdef BLOCK_MOVE_CTRL_WRAP_EN
    if (v < 0)         return vmax[9:0];
    else if (v > vmax) return 10'd0;
    else               return v[9:0];
`else
    if (v < 0)         return 10'd0;
    else if (v > vmax) return vmax[9:0];
    else               return v[9:0];
`endif
  endfunction

  always_comb begin
    bx_d = bound(nx_q, XMax);
    by_d = bound(ny_q, YMax);
  end

  // Key synchronizer and per-bit debounce.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      key_db  <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= ~key;
      sync2_q <= sync1_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == key_db[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntW'(DEB_CYCLES - 1)) begin
          key_db[i] <= sync2_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state_q <= StIdle;
      dir_q   <= '0;
      nx_q    <= '0;
      ny_q    <= '0;
      block_x <= 10'(X_INIT);
      block_y <= 10'(Y_INIT);
      moving  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (frame_start) begin
            dir_q   <= key_db;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          nx_q    <= axis_step(block_x, dir_q[0], dir_q[1]);
          ny_q    <= axis_step(block_y, dir_q[2], dir_q[3]);
          state_q <= StCommit;
        end
        StCommit: begin
          block_x <= bx_d;
          block_y <= by_d;
          moving  <= (bx_d != block_x) || (by_d != block_y);
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
